// File: rtl/cpu_readback_pkg.sv
// -----------------------------------------------------------------------------
// cpu_readback_pkg
// Shared definitions for the CPU read responder: the FSM state encoding, the
// controller-region address map for the internal status words, and the BRAM
// select code that the responder serves.
// -----------------------------------------------------------------------------
package cpu_readback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRIVE   = 2'd3
  } state_t;

  // SYS_TIME is exposed as four consecutive words, least significant first.
  localparam logic [13:0] ADDR_SYS_TIME0 = 14'h0F0;
  localparam logic [13:0] ADDR_SYS_TIME1 = 14'h0F1;
  localparam logic [13:0] ADDR_SYS_TIME2 = 14'h0F2;
  localparam logic [13:0] ADDR_SYS_TIME3 = 14'h0F3;
  localparam logic [13:0] ADDR_VERSION   = 14'h0FC;
  localparam logic [13:0] ADDR_STATUS    = 14'h0FD;
  localparam logic [13:0] ADDR_RD_CNT    = 14'h0FE;

  localparam logic [1:0]  BRAM_SELECT_CONTROLLER = 2'b00;

endpackage

// File: rtl/cpu_readback_word_mux.sv
// -----------------------------------------------------------------------------
// readback_word_mux
// Registered address-to-word mux for the read responder. On i_load the word
// selected by i_addr is captured into o_data and held until the next load.
//
// Optional feature (macro READBACK_SNAPSHOT_EN): a load of the first SYS_TIME
// word also snapshots the upper 48 bits of SYS_TIME, so the three follow-up
// word reads return a value coherent with the first one. Without the macro
// every SYS_TIME word is taken live and no snapshot register exists.
//
// Ports
//   CLK, RST      clock, synchronous active-high reset
//   i_load        capture the selected word this cycle
//   i_is_reg      i_addr falls in the register-file range
//   i_addr        latched word address
//   i_reg_data    register-file read data
//   i_sys_time    system time
//   i_thermo      thermal input
//   i_force_fan   fan-force state
//   i_rd_cnt      current read counter (value before this read's increment)
//   o_data        registered read word
// -----------------------------------------------------------------------------
module readback_word_mux
  import cpu_readback_pkg::*;
#(
  parameter logic [15:0] VERSION = 16'h0080
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_load,
  input  logic        i_is_reg,
  input  logic [13:0] i_addr,
  input  logic [15:0] i_reg_data,
  input  logic [63:0] i_sys_time,
  input  logic        i_thermo,
  input  logic        i_force_fan,
  input  logic [15:0] i_rd_cnt,
  output logic [15:0] o_data
);

  logic [63:0] w_time;
  logic [15:0] w_word;

`ifdef READBACK_SNAPSHOT_EN
  // The low word leaves immediately through o_data, so only the upper three
  // words need to be held for the follow-up reads.
  logic [47:0] r_snap;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_snap <= '0;
    end else if (i_load && (i_addr == ADDR_SYS_TIME0)) begin
      r_snap <= i_sys_time[63:16];
    end
  end

  assign w_time = {r_snap, i_sys_time[15:0]};
`else
  assign w_time = i_sys_time;
`endif

  // NOTE: w_word is given a default before any branch so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    w_word = 16'h0000;
    if (i_is_reg) begin
      w_word = i_reg_data;
    end else begin
      case (i_addr)
        ADDR_SYS_TIME0: w_word = w_time[15:0];
        ADDR_SYS_TIME1: w_word = w_time[31:16];
        ADDR_SYS_TIME2: w_word = w_time[47:32];
        ADDR_SYS_TIME3: w_word = w_time[63:48];
        ADDR_VERSION:   w_word = VERSION;
        ADDR_STATUS:    w_word = {14'b0, i_force_fan, i_thermo};
        ADDR_RD_CNT:    w_word = i_rd_cnt;
        default:        w_word = 16'h0000;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      o_data <= 16'h0000;
    end else if (i_load) begin
      o_data <= w_word;
    end
  end

endmodule

// File: rtl/cpu_readback.sv
// -----------------------------------------------------------------------------
// cpu_readback
// CPU-bus read responder for the controller region. A qualified read cycle is
// answered three cycles later with DATA_OE high and DATA_OUT stable, whatever
// the address: register-file addresses are fetched through REG_RE/REG_ADDR,
// the rest come from internal status words. Dropping BUS_RD or BUS_EN before
// the data phase aborts the read without driving the bus.
//
// Optional feature: define READBACK_SNAPSHOT_EN for a coherent 64-bit
// SYS_TIME snapshot taken when word 0 is read.
//
// Ports
//   CLK, RST              CPU bus clock, synchronous active-high reset
//   BUS_EN/RD/WE/RDWR     chip-select and strobes, all active-high
//   BUS_SELECT, BUS_ADDR  BRAM select and word address
//   REG_RE, REG_ADDR      register-file read port
//   REG_DATA              register-file data, one cycle after REG_RE
//   SYS_TIME, THERMO, FORCE_FAN  status sources
//   DATA_OUT, DATA_OE     read data and CPU_DATA drive enable
// -----------------------------------------------------------------------------
module cpu_readback
  import cpu_readback_pkg::*;
#(
  parameter int          NUM_REGS = 64,
  parameter logic [15:0] VERSION  = 16'h0080
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BUS_EN,
  input  logic        BUS_RD,
  input  logic        BUS_WE,
  input  logic        BUS_RDWR,
  input  logic [1:0]  BUS_SELECT,
  input  logic [13:0] BUS_ADDR,
  output logic        REG_RE,
  output logic [7:0]  REG_ADDR,
  input  logic [15:0] REG_DATA,
  input  logic [63:0] SYS_TIME,
  input  logic        THERMO,
  input  logic        FORCE_FAN,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE
);

  localparam logic [13:0] LP_NUM_REGS = 14'(NUM_REGS);

  state_t      r_state;
  state_t      w_next;
  logic [13:0] r_addr;
  logic [15:0] r_rd_cnt;
  logic        w_req;
  logic        w_hold;
  logic        w_is_reg;
  logic        w_load;

  // A write strobe alongside the read condition means the write path owns
  // the cycle, so the responder stays out of it.
  assign w_req = BUS_EN & BUS_RD & BUS_RDWR & ~BUS_WE &
                 (BUS_SELECT == BRAM_SELECT_CONTROLLER);
  assign w_hold   = BUS_EN & BUS_RD;
  assign w_is_reg = (r_addr < LP_NUM_REGS);

  always_comb begin
    w_next   = r_state;
    REG_RE   = 1'b0;
    REG_ADDR = 8'h00;
    DATA_OE  = 1'b0;
    w_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        REG_RE   = w_is_reg;
        REG_ADDR = w_is_reg ? r_addr[7:0] : 8'h00;
        w_next   = w_hold ? ST_CAPTURE : ST_IDLE;
      end
      ST_CAPTURE: begin
        // Capture and count only when the read really goes on to DRIVE.
        if (w_hold) begin
          w_load = 1'b1;
          w_next = ST_DRIVE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        DATA_OE = 1'b1;
        w_next  = w_hold ? ST_DRIVE : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_rd_cnt <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && w_req) r_addr <= BUS_ADDR;
      // The mux samples r_rd_cnt on the same edge, so a counter read
      // returns the value before its own increment.
      if (w_load) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end

  readback_word_mux #(
    .VERSION (VERSION)
  ) u_word_mux (
    .CLK         (CLK),
    .RST         (RST),
    .i_load      (w_load),
    .i_is_reg    (w_is_reg),
    .i_addr      (r_addr),
    .i_reg_data  (REG_DATA),
    .i_sys_time  (SYS_TIME),
    .i_thermo    (THERMO),
    .i_force_fan (FORCE_FAN),
    .i_rd_cnt    (r_rd_cnt),
    .o_data      (DATA_OUT)
  );

endmodule

// File: doc/cpu_readback.md
# cpu_readback

CPU-bus read responder: the read-direction counterpart of the CPU write path that fills the controller, normal, STM and modulator memories. It decodes CPU read cycles in the controller region and fetches the addressed word from the controller register file, or from one of several internal status words. It drives it onto a 16-bit data output with an output-enable that the top level uses for the `CPU_DATA` tristate. It sits in the CPU bus clock domain, beside `controller`, and sources `SYS_TIME` and status from the rest of the design.

## Interface
- `NUM_REGS`, 64: controller register-file depth; addresses `0..NUM_REGS-1` are forwarded to the register port.
- `VERSION`, 16'h0080: constant returned at the version address.
- `CLK` in 1: CPU bus clock; single clock for the whole block.
- `RST` in 1: reset, synchronous, active-high.
- `BUS_EN` in 1: chip-select, already inverted to active-high.
- `BUS_RD` in 1: read strobe, active-high.
- `BUS_WE` in 1: write strobe, active-high.
- `BUS_RDWR` in 1: 1 = read cycle.
- `BUS_SELECT` in 2: BRAM select; only `2'b00` (controller) is served.
- `BUS_ADDR` in 14: word address.
- `REG_RE` out 1: register-file read enable.
- `REG_ADDR` out 8: register-file address.
- `REG_DATA` in 16: register-file data, valid 1 cycle after `REG_RE`.
- `SYS_TIME` in 64: system time, already synchronous to `CLK`.
- `THERMO` in 1: thermal input.
- `FORCE_FAN` in 1: current fan-force state.
- `DATA_OUT` out 16: read data.
- `DATA_OE` out 1: drive enable for the `CPU_DATA` tristate.

## Operation
- Read request:
  - Condition: `BUS_EN & BUS_RD & BUS_RDWR & ~BUS_WE & BUS_SELECT==2'b00`, sampled in IDLE.
  - `BUS_WE` high together with the read condition means write wins; the request is ignored.
- Address map:
  - `0x000..NUM_REGS-1`: register file.
  - `0x0F0..0x0F3`: `SYS_TIME` words 0..3, LSW first.
  - `0x0FC`: `VERSION`.
  - `0x0FD`: `{14'b0, FORCE_FAN, THERMO}`.
  - `0x0FE`: read counter.
  - All other addresses: `16'h0000`. The responder still drives for these.
- State machine, states IDLE, FETCH, CAPTURE, DRIVE:
  - IDLE → FETCH on a request. Latch `BUS_ADDR`.
  - FETCH: `REG_RE=1` and `REG_ADDR=addr[7:0]`, only for register-file addresses. → CAPTURE.
  - CAPTURE: mux `REG_DATA` or internal word into the output register. → DRIVE.
  - DRIVE: `DATA_OE=1`, `DATA_OUT` stable. Stay while `BUS_RD & BUS_EN`; otherwise → IDLE.
  - In FETCH or CAPTURE, if `BUS_RD` or `BUS_EN` drops: → IDLE. The read is aborted, `DATA_OE` is never asserted and the counter does not increment.
- Read counter:
  - 16 bits; increments on each entry to DRIVE; wraps `0xFFFF→0x0000`.
  - A read of the counter returns the value before its own increment.
- `SYS_TIME` coherence: see Configuration.

## Timing
- Cycle 0: request sampled in IDLE.
- Cycle 1: FETCH, `REG_RE` high.
- Cycle 2: CAPTURE.
- Cycle 3: `DATA_OE=1` with valid `DATA_OUT`; latency is 3 cycles, identical for every address.
- `DATA_OE` falls on the first cycle after `BUS_RD` or `BUS_EN` is seen low.
- Back-to-back reads need one IDLE cycle between them.
- Reset values: state IDLE, `DATA_OE=0`, `DATA_OUT=0`, `REG_RE=0`, `REG_ADDR=0`, counter 0, snapshot 0.
- `RST` asserted in any state gives `DATA_OE=0` on the next edge.
- `REG_RE` is high for exactly 1 cycle per register-file read.

## Configuration
- `READBACK_SNAPSHOT_EN` defined:
  - Reading `0x0F0` latches all 64 bits of `SYS_TIME` in CAPTURE and returns bits [15:0].
  - Reads of `0x0F1..0x0F3` return the snapshot.
- Undefined: all four words return live `SYS_TIME` at CAPTURE, and no snapshot register is instantiated.

## Structure
- Shared package `cpu_readback_pkg`: state enum, address constants (`ADDR_SYS_TIME0`, `ADDR_VERSION`, `ADDR_STATUS`, `ADDR_RD_CNT`) and the `BRAM_SELECT_CONTROLLER` constant.
- One sub-module, `readback_word_mux`: a registered address-to-word mux that includes the snapshot logic.

## Test plan
- Register read: read addr `0x005` with the register model returning `16'hBEEF` → `REG_RE` pulse at cycle 1 with `REG_ADDR=5`; `DATA_OE=1` at cycle 3 with `DATA_OUT=16'hBEEF`; `DATA_OE` low 1 cycle after `RD` falls.
- Snapshot: `SYS_TIME=64'h0001_0002_0003_FFFF`; read `0x0F0`, then advance time past a carry, then read `0x0F1..0x0F3`:
  - With the macro: returns `FFFF`, `0003`, `0002`, `0001`.
  - Without the macro: returns live values.
- Abort: `RD` drops in CAPTURE → `DATA_OE` never asserted; a subsequent read of `0x0FE` returns the unchanged count.
- Counter wrap: preload via 65535 reads, then read `0x0FE` twice → `0xFFFF`, then `0x0000`.
- Filtering:
  - `BUS_SELECT=2'b01` → no `REG_RE` and no `DATA_OE`.
  - `RD` and `WE` high together → ignored.
  - Unmapped addr `0x0FF` → `DATA_OUT=0` with `DATA_OE=1`.
- Reset in DRIVE: `RST` high for 1 cycle while `DATA_OE=1` → `DATA_OE=0` next edge; all outputs at reset values.
